// File: rtl/cover_toggle_collector_if.sv
// Valid/ready stream carrying absolute cover indices out of a toggle-coverage collector.
interface cover_toggle_collector_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_index;

  modport master (output out_valid, output out_index, input out_ready);
  modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-coverage collector: records first hits per cover point and streams
// each newly covered point once as an absolute cover index.
module cover_toggle_collector #(
  parameter int              WIDTH       = 62,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 38253
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           valid,
  cover_toggle_collector_if.master   out_if,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       all_hit,
  output logic                       pending
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_t;

  // Elaboration-time sanity checks on the group placement.
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH out of range 1..1024");
  end
  if (COVER_INDEX + 64'(WIDTH) > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  state_t          r_state;
  logic [WIDTH-1:0] r_hit_q;
  logic [WIDTH-1:0] r_pend_q;
  logic [PW-1:0]    r_ptr;
  logic             r_out_valid;
  logic [63:0]      r_out_index;
  logic [CW-1:0]    r_hit_count;
  logic             r_all_hit;
  logic             r_clr_seen;

  logic             w_capture;
  logic [WIDTH-1:0] w_new;
  logic [WIDTH-1:0] w_pend_cap;
  logic [WIDTH-1:0] w_take_mask;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_count_next;
  logic [PW-1:0]    w_ptr_inc;
  logic             w_found;

  assign w_capture = enable & ~clear;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_new
    assign w_new[gi] = w_capture & valid[gi] & ~r_hit_q[gi];
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CW'(w_new[i]);
    end
  end

  // Only never-before-hit points are added, so this sum stays within WIDTH.
  assign w_count_next = r_hit_count + w_pop;
  assign w_pend_cap   = r_pend_q | w_new;
  assign w_found      = (r_state == S_SCAN) && r_pend_q[r_ptr];
  assign w_take_mask  = w_found ? (WIDTH'(1) << r_ptr) : '0;
  assign w_ptr_inc    = (r_ptr == PTR_LAST) ? '0 : r_ptr + PW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hit_q     <= '0;
      r_pend_q    <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_hit_count <= '0;
      r_all_hit   <= 1'b0;
      r_clr_seen  <= 1'b0;
    end else begin
      if (clear) begin
        r_hit_q     <= '0;
        r_pend_q    <= '0;
        r_hit_count <= '0;
        r_all_hit   <= 1'b0;
      end else begin
        r_hit_q     <= r_hit_q | w_new;
        r_pend_q    <= w_pend_cap & ~w_take_mask;
        r_hit_count <= w_count_next;
        r_all_hit   <= (w_count_next == CW'(WIDTH));
      end

      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_ptr <= '0;
          end else if (|r_pend_q) begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // A capture of the bit under examination only shows up on the next wrap.
          if (clear) begin
            r_ptr   <= '0;
            r_state <= S_IDLE;
          end else if (w_pend_cap == '0) begin
            r_state <= S_IDLE;
          end else if (w_found) begin
            r_out_index <= COVER_INDEX + 64'(r_ptr);
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_ptr <= w_ptr_inc;
          end
        end
        S_OUT: begin
          // A clear never retracts the held beat; it only redirects what follows.
          if (clear) begin
            r_clr_seen <= 1'b1;
          end
          if (out_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_clr_seen  <= 1'b0;
            if (clear || r_clr_seen) begin
              r_ptr   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_ptr   <= w_ptr_inc;
              r_state <= S_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_if.out_valid = r_out_valid;
  assign out_if.out_index = r_out_index;
  assign hit_count        = r_hit_count;
  assign all_hit          = r_all_hit;
  assign pending          = (|r_pend_q) | r_out_valid;

endmodule

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
- Hardware-side consumer of toggle-coverage hit vectors: the receiving end of the per-bit cover-point reporting.
- Takes a WIDTH-bit valid vector each cycle and keeps a sticky covered bitmap.
- Reports each cover point's first hit once, as an absolute cover index, over a valid/ready stream.
- Sits beside a design instance in formal and FPGA builds, where DPI is unavailable; the stream feeds a coverage sink or FIFO.

Parameters:
- WIDTH, 62, number of cover points in this group; valid range 1..1024.
- COVER_INDEX, 0, absolute index of bit 0 of this group.
- COVER_TOTAL, 38253, total cover points in the design; simulation-only check that COVER_INDEX+WIDTH <= COVER_TOTAL.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when 1, valid is sampled; when 0, valid is ignored.
- clear  in  1  synchronous clear of the covered bitmap and pending bitmap.
- valid  in  WIDTH  per-cover-point hit strobes for this cycle.
- out_valid  out  1  out_index holds a reportable cover index.
- out_ready  in  1  sink accepts the beat when out_valid&&out_ready.
- out_index  out  64  absolute cover index: COVER_INDEX+bit.
- hit_count  out  $clog2(WIDTH+1)  number of distinct points covered since reset or clear.
- all_hit  out  1  high when hit_count==WIDTH.
- pending  out  1  high when |pend_q or out_valid.

Behaviour:
- State:
  - hit_q[WIDTH] is the sticky covered bitmap.
  - pend_q[WIDTH] marks points covered but not yet reported.
  - ptr is the scan pointer, range 0..WIDTH-1.
  - The FSM has three states: IDLE, SCAN, OUT.
- Reset (reset==0, asynchronous):
  - hit_q=0, pend_q=0, ptr=0, FSM=IDLE.
  - out_valid=0, out_index=0, hit_count=0, all_hit=0 (WIDTH>0), pending=0.
  - Takes effect immediately, mid-beat included; an unaccepted beat is dropped.
- Capture, every cycle with enable==1 and clear==0:
  - new = valid & ~hit_q.
  - hit_q |= new; pend_q |= new.
  - hit_count += popcount(new).
  - A point already in hit_q never re-enters pend_q, so each point is reported at most once per reset or clear epoch.
- FSM:
  - IDLE: if pend_q!=0, go to SCAN next cycle; otherwise stay.
  - SCAN, one bit per cycle:
    - If pend_q[ptr]: out_index<=COVER_INDEX+ptr (64-bit zero-extended add), out_valid<=1, pend_q[ptr]<=0, go to OUT.
    - Otherwise ptr<=ptr+1, wrapping WIDTH-1 to 0.
    - If pend_q (including this cycle's captures) becomes 0, go to IDLE with ptr unchanged.
  - OUT:
    - Hold out_valid and out_index stable until out_ready.
    - On accept: out_valid<=0, ptr<=(ptr+1) wrapping, go to SCAN.
- Latency:
  - Capture is visible in hit_count and pending the cycle after the valid strobe.
  - With out_ready held at 1, the first beat appears 2..WIDTH+2 cycles after the strobe.
  - Sustained rate is at most one beat per 2 cycles.
- clear==1:
  - Next cycle: hit_q=0, pend_q=0, hit_count=0, all_hit=0.
  - valid hits in the same cycle as clear are discarded (clear wins).
  - A beat already in OUT is not retracted: it stays valid until accepted, then ptr becomes 0 and the FSM goes to IDLE.
  - If not in OUT, ptr becomes 0 and the FSM goes to IDLE.
- Simultaneous events:
  - A capture of bit k in the same cycle SCAN examines bit k has no effect on this examination; bit k is seen on the next wrap.
  - A capture during OUT only sets pend_q.
- Arithmetic: hit_count never exceeds WIDTH; the popcount adder is sized so it cannot wrap.
- Whole block is simulation and synthesis clean; no DPI.

Test Plan:
- Reset: drive reset=0 with random valid/clear/out_ready, then reset=1 with enable=0 → out_valid=0, out_index=0, hit_count=0, all_hit=0, pending=0.
- Single point (WIDTH=62, COVER_INDEX=100, out_ready=1): valid[5] for 1 cycle → hit_count=1 next cycle; exactly one beat out_index=105 within 64 cycles. valid[5] again → no further beat, hit_count stays 1.
- Dual same-cycle: valid bits 0 and 61 together, ptr=0 → hit_count=2; beats 100 then 161, each exactly once; FSM returns to IDLE, pending=0.
- Backpressure: out_ready=0 for 20 cycles while out_valid=1 → out_index stable throughout. Strobe valid[10] during the stall → after release, beat 110 follows the held beat.
- Clear mid-beat: out_valid=1 with index 105 unaccepted, pulse clear → 105 stays held until out_ready, hit_count=0 next cycle. Re-strobe valid[5] → second 105 beat. clear and valid[7] in the same cycle → no 107 beat.
- Full coverage and async reset: valid all ones for 1 cycle → hit_count=62, all_hit=1; 62 beats in order 100..161. Drop reset to 0 mid-stream → out_valid falls immediately, hit_count=0; no further beats after release.
